// File: rtl/idu_pipe.sv
// idu_pipe: instruction decode stage with a small output queue and a register
// busy scoreboard.
//
// Decodes one 32-bit RV instruction per cycle into class, immediate, rd/rd_wen
// and illegal flags. It reads both source registers, then pushes the result
// into a DEPTH-entry FIFO that feeds execute. A 32-bit busy scoreboard tracks
// destinations still in flight and stalls fetch while a used source is busy.
//
// Ports
//   clk, rst                  clock; asynchronous active-low reset
//   ifu_valid/ifu_ready       fetch handshake; ifu_inst, ifu_pc bundle
//   rs1_addr/rs2_addr         register-file read addresses (inst fields)
//   rs1_data/rs2_data         register-file read data
//   idu_valid/exu_ready       execute handshake on the queue head
//   idu_pc .. idu_illegal     queue head fields
//   wb_valid/wb_rd            writeback retire, clears a busy bit
//   flush                     drop queue contents and all busy bits
//   idu_count                 queue occupancy
module idu_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ifu_valid,
  output logic                     ifu_ready,
  input  logic [31:0]              ifu_inst,
  input  logic [XLEN-1:0]          ifu_pc,
  output logic [4:0]               rs1_addr,
  output logic [4:0]               rs2_addr,
  input  logic [XLEN-1:0]          rs1_data,
  input  logic [XLEN-1:0]          rs2_data,
  output logic                     idu_valid,
  input  logic                     exu_ready,
  output logic [XLEN-1:0]          idu_pc,
  output logic [31:0]              idu_inst,
  output logic [XLEN-1:0]          idu_imm,
  output logic [XLEN-1:0]          idu_rs1_data,
  output logic [XLEN-1:0]          idu_rs2_data,
  output logic [4:0]               idu_rd_addr,
  output logic                     idu_rd_wen,
  output logic [9:0]               idu_class,
  output logic                     idu_illegal,
  input  logic                     wb_valid,
  input  logic [4:0]               wb_rd,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   idu_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam int C_LUI    = 0;
  localparam int C_AUIPC  = 1;
  localparam int C_JAL    = 2;
  localparam int C_JALR   = 3;
  localparam int C_BRANCH = 4;
  localparam int C_LOAD   = 5;
  localparam int C_STORE  = 6;
  localparam int C_OPIMM  = 7;
  localparam int C_OP     = 8;
  localparam int C_SYSTEM = 9;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd;
    logic            rd_wen;
    logic [9:0]      cls;
    logic            illegal;
  } entry_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rd;
  logic [9:0]      cls;
  logic            illegal;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm;
  logic            sys_rs1;
  logic            rs1_used;
  logic            rs2_used;
  logic            rd_wen;
  logic            hazard;
  logic            full;
  logic            push;
  logic            pop;

  logic [31:0]     busy;
  logic [31:0]     busy_nxt;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  entry_t          q_mem [DEPTH];

  assign opcode   = ifu_inst[6:0];
  assign funct3   = ifu_inst[14:12];
  assign rd       = ifu_inst[11:7];
  assign rs1_addr = ifu_inst[19:15];
  assign rs2_addr = ifu_inst[24:20];

  always_comb begin
    cls     = '0;
    illegal = 1'b0;
    case (opcode)
      7'b0110111: cls[C_LUI]    = 1'b1;
      7'b0010111: cls[C_AUIPC]  = 1'b1;
      7'b1101111: cls[C_JAL]    = 1'b1;
      7'b1100111: cls[C_JALR]   = 1'b1;
      7'b1100011: cls[C_BRANCH] = 1'b1;
      7'b0000011: cls[C_LOAD]   = 1'b1;
      7'b0100011: cls[C_STORE]  = 1'b1;
      7'b0010011: cls[C_OPIMM]  = 1'b1;
      7'b0110011: cls[C_OP]     = 1'b1;
      7'b1110011: cls[C_SYSTEM] = 1'b1;
      default:    illegal       = 1'b1;
    endcase
  end

  // OP, SYSTEM and illegal fall through to a zero immediate.
  always_comb begin
    imm32 = '0;
    if (cls[C_LUI] | cls[C_AUIPC])
      imm32 = {ifu_inst[31:12], 12'b0};
    else if (cls[C_JAL])
      imm32 = {{12{ifu_inst[31]}}, ifu_inst[19:12], ifu_inst[20], ifu_inst[30:21], 1'b0};
    else if (cls[C_BRANCH])
      imm32 = {{20{ifu_inst[31]}}, ifu_inst[7], ifu_inst[30:25], ifu_inst[11:8], 1'b0};
    else if (cls[C_STORE])
      imm32 = {{21{ifu_inst[31]}}, ifu_inst[30:25], ifu_inst[11:7]};
    else if (cls[C_JALR] | cls[C_LOAD] | cls[C_OPIMM])
      imm32 = {{21{ifu_inst[31]}}, ifu_inst[30:20]};
  end

  // Signed size cast sign-extends to XLEN (a no-op at XLEN=32).
  assign imm = XLEN'($signed(imm32));

  // Only the register forms of CSR access (funct3 1..3) read rs1.
  assign sys_rs1  = cls[C_SYSTEM] & (funct3 != 3'd0) & ~funct3[2];
  assign rs1_used = cls[C_JALR] | cls[C_BRANCH] | cls[C_LOAD] | cls[C_STORE] |
                    cls[C_OPIMM] | cls[C_OP] | sys_rs1;
  assign rs2_used = cls[C_BRANCH] | cls[C_STORE] | cls[C_OP];
  assign rd_wen   = (cls[C_LUI] | cls[C_AUIPC] | cls[C_JAL] | cls[C_JALR] |
                     cls[C_LOAD] | cls[C_OPIMM] | cls[C_OP] |
                     (cls[C_SYSTEM] & (funct3 != 3'd0))) & (rd != 5'd0);

  // busy[0] is held at 0, so x0 never raises a hazard.
  assign hazard = (rs1_used & busy[rs1_addr]) | (rs2_used & busy[rs2_addr]);

  assign full      = (idu_count == CW'(DEPTH));
  assign ifu_ready = ~full & ~hazard & ~flush;
  assign idu_valid = (idu_count != '0);
  assign push      = ifu_valid & ifu_ready;
  assign pop       = idu_valid & exu_ready;

  // Clear first, then set, so a same-cycle retire and re-allocation of one
  // register leaves it busy.
  always_comb begin
    busy_nxt = busy;
    if (wb_valid)
      busy_nxt[wb_rd] = 1'b0;
    if (push & rd_wen)
      busy_nxt[rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      busy <= '0;
    else if (flush)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idu_count <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else if (flush) begin
      idu_count <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   idu_count <= idu_count + 1'b1;
        2'b01:   idu_count <= idu_count - 1'b1;
        default: idu_count <= idu_count;
      endcase
    end
  end

  // Entries are reset so the head fields read zero while in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        q_mem[i] <= '0;
    end else if (push) begin
      q_mem[wr_ptr] <= '{pc: ifu_pc, inst: ifu_inst, imm: imm,
                         rs1_data: rs1_data, rs2_data: rs2_data,
                         rd: rd, rd_wen: rd_wen, cls: cls, illegal: illegal};
    end
  end

  assign idu_pc       = q_mem[rd_ptr].pc;
  assign idu_inst     = q_mem[rd_ptr].inst;
  assign idu_imm      = q_mem[rd_ptr].imm;
  assign idu_rs1_data = q_mem[rd_ptr].rs1_data;
  assign idu_rs2_data = q_mem[rd_ptr].rs2_data;
  assign idu_rd_addr  = q_mem[rd_ptr].rd;
  assign idu_rd_wen   = q_mem[rd_ptr].rd_wen;
  assign idu_class    = q_mem[rd_ptr].cls;
  assign idu_illegal  = q_mem[rd_ptr].illegal;

endmodule

// File: tb/tb_idu_pipe.sv
// tb_idu_pipe: self-checking bench for idu_pipe (XLEN=64, DEPTH=2).
// A table of hand-decoded instructions is streamed through the queue, then
// directed sequences cover load-use stall, full queue, flush, busy set/clear
// collision and asynchronous reset. Expected head entries go into a
// scoreboard queue when the bench expects a push and are compared on pop.
module tb_idu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_valid, ifu_ready;
  logic [31:0] ifu_inst;
  logic [63:0] ifu_pc;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [63:0] rs1_data, rs2_data;
  logic        idu_valid, exu_ready;
  logic [63:0] idu_pc, idu_imm, idu_rs1_data, idu_rs2_data;
  logic [31:0] idu_inst;
  logic [4:0]  idu_rd_addr;
  logic        idu_rd_wen, idu_illegal;
  logic [9:0]  idu_class;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic [1:0]  idu_count;

  logic [63:0] regs [32];
  assign rs1_data = regs[rs1_addr];
  assign rs2_data = regs[rs2_addr];

  idu_pipe #(.XLEN(64), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .ifu_valid(ifu_valid), .ifu_ready(ifu_ready), .ifu_inst(ifu_inst), .ifu_pc(ifu_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .idu_valid(idu_valid), .exu_ready(exu_ready), .idu_pc(idu_pc), .idu_inst(idu_inst),
    .idu_imm(idu_imm), .idu_rs1_data(idu_rs1_data), .idu_rs2_data(idu_rs2_data),
    .idu_rd_addr(idu_rd_addr), .idu_rd_wen(idu_rd_wen), .idu_class(idu_class),
    .idu_illegal(idu_illegal), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .idu_count(idu_count)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                         OP_JALR = 7'b1100111, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_OPIMM = 7'b0010011,
                         OP_OP = 7'b0110011, OP_SYS = 7'b1110011;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [63:0] imm;
    logic [63:0] rs1d;
    logic [63:0] rs2d;
    logic [4:0]  rd;
    logic        wen;
    logic [9:0]  cls;
    logic        ill;
  } exp_t;

  exp_t        sb [$];
  exp_t        mon_e;
  exp_t        vt [17];
  int          n_chk = 0;
  int          n_err = 0;
  logic [63:0] next_pc = 64'h8000_0000;

  function automatic logic [31:0] enc_i(logic [11:0] im, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
    return {im, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(logic [11:0] im, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {im[11:5], rs2, rs1, f3, im[4:0], OP_STORE};
  endfunction
  function automatic logic [31:0] enc_b(logic [12:0] im, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_u(logic [19:0] im, logic [4:0] rd, logic [6:0] op);
    return {im, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(logic [20:0] im, logic [4:0] rd);
    return {im[20], im[10:1], im[11], im[19:12], rd, 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_r(logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd);
    return {7'b0, rs2, rs1, f3, rd, OP_OP};
  endfunction

  function automatic exp_t mk(logic [31:0] inst, logic [63:0] imm, logic [9:0] cls,
                              logic wen, logic ill);
    exp_t e;
    e.pc   = next_pc;
    next_pc = next_pc + 64'd4;
    e.inst = inst;
    e.imm  = imm;
    e.rd   = inst[11:7];
    e.wen  = wen;
    e.cls  = cls;
    e.ill  = ill;
    e.rs1d = '0;
    e.rs2d = '0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Offer one bundle for one cycle; record it in the scoreboard if the bench
  // expects it to be accepted. Leaves the bench at posedge+1.
  task automatic offer(input exp_t e, input logic exp_rdy);
    exp_t s;
    ifu_valid = 1'b1;
    ifu_inst  = e.inst;
    ifu_pc    = e.pc;
    @(negedge clk);
    chk("ifu_ready", ifu_ready, exp_rdy);
    if (exp_rdy) begin
      s = e;
      s.rs1d = regs[e.inst[19:15]];
      s.rs2d = regs[e.inst[24:20]];
      sb.push_back(s);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ifu_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_flush();
    ifu_valid = 1'b0;
    flush = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst && !flush && idu_valid && exu_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_pop: got pc %h expected no entry", idu_pc);
      end else begin
        mon_e = sb.pop_front();
        chk("head_pc", idu_pc, mon_e.pc);
        chk("head_inst", {32'd0, idu_inst}, {32'd0, mon_e.inst});
        chk("head_imm", idu_imm, mon_e.imm);
        chk("head_rs1", idu_rs1_data, mon_e.rs1d);
        chk("head_rs2", idu_rs2_data, mon_e.rs2d);
        chk("head_rd", {59'd0, idu_rd_addr}, {59'd0, mon_e.rd});
        chk("head_wen", {63'd0, idu_rd_wen}, {63'd0, mon_e.wen});
        chk("head_class", {54'd0, idu_class}, {54'd0, mon_e.cls});
        chk("head_illegal", {63'd0, idu_illegal}, {63'd0, mon_e.ill});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t a, b, c;
    for (int i = 0; i < 32; i++)
      regs[i] = (i == 0) ? 64'd0 : 64'h1000_0000_0000_0000 + 64'(i) * 64'h0101;

    vt[0]  = mk(enc_u(20'h12345, 5'd1, OP_LUI),   64'h0000_0000_1234_5000, 10'h001, 1, 0);
    vt[1]  = mk(enc_u(20'h80000, 5'd2, OP_LUI),   64'hFFFF_FFFF_8000_0000, 10'h001, 1, 0);
    vt[2]  = mk(enc_u(20'hFFFFF, 5'd3, OP_AUIPC), 64'hFFFF_FFFF_FFFF_F000, 10'h002, 1, 0);
    vt[3]  = mk(enc_j(21'h1FFFF8, 5'd4),          64'hFFFF_FFFF_FFFF_FFF8, 10'h004, 1, 0);
    vt[4]  = mk(enc_i(12'h7FF, 5'd20, 3'd0, 5'd5, OP_JALR), 64'h7FF, 10'h008, 1, 0);
    vt[5]  = mk(enc_b(13'h1FFC, 5'd21, 5'd20, 3'd0), 64'hFFFF_FFFF_FFFF_FFFC, 10'h010, 0, 0);
    vt[6]  = mk(enc_i(12'h800, 5'd21, 3'd2, 5'd6, OP_LOAD), 64'hFFFF_FFFF_FFFF_F800, 10'h020, 1, 0);
    vt[7]  = mk(enc_s(12'h123, 5'd21, 5'd20, 3'd2), 64'h123, 10'h040, 0, 0);
    vt[8]  = mk(enc_i(12'hFFF, 5'd20, 3'd0, 5'd7, OP_OPIMM), 64'hFFFF_FFFF_FFFF_FFFF, 10'h080, 1, 0);
    vt[9]  = mk(enc_r(5'd21, 5'd20, 3'd0, 5'd8), 64'h0, 10'h100, 1, 0);
    vt[10] = mk(enc_i(12'h300, 5'd20, 3'd1, 5'd9, OP_SYS), 64'h0, 10'h200, 1, 0);
    // SYSTEM funct3=0 and funct3=5 name busy registers in rs1 but must not stall.
    vt[11] = mk(enc_i(12'h000, 5'd1, 3'd0, 5'd0, OP_SYS), 64'h0, 10'h200, 0, 0);
    vt[12] = mk(32'h0000_0500, 64'h0, 10'h000, 0, 1);
    vt[13] = mk(enc_i(12'h005, 5'd0, 3'd0, 5'd0, OP_OPIMM), 64'h5, 10'h080, 0, 0);
    // Illegal opcode whose rs1/rs2 fields are x8/x3, both busy here.
    vt[14] = mk(32'h1234_567F, 64'h0, 10'h000, 0, 1);
    vt[15] = mk(enc_i(12'h300, 5'd2, 3'd5, 5'd10, OP_SYS), 64'h0, 10'h200, 1, 0);
    // OPIMM with imm[4:0]=1 names busy x1 in the rs2 field.
    vt[16] = mk(enc_i(12'h001, 5'd20, 3'd0, 5'd12, OP_OPIMM), 64'h1, 10'h080, 1, 0);

    rst = 1'b0;
    ifu_valid = 1'b0; ifu_inst = '0; ifu_pc = '0;
    exu_ready = 1'b0; wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
    #2;
    chk("rst_valid", {63'd0, idu_valid}, 64'd0);
    chk("rst_count", {62'd0, idu_count}, 64'd0);
    chk("rst_pc", idu_pc, 64'd0);
    #8;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Stream the decode table with execute always ready: occupancy stays <= 1.
    exu_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      chk("stream_count", {62'd0, idu_count}, (i == 0) ? 64'd0 : 64'd1);
      offer(vt[i], 1'b1);
    end
    idle(2);
    chk("stream_drained", {62'd0, idu_count}, 64'd0);
    do_flush();

    // Load-use stall on x5, released by writeback; ADD sees the new x5.
    exu_ready = 1'b1;
    a = mk(enc_i(12'h010, 5'd20, 3'd2, 5'd5, OP_LOAD), 64'h10, 10'h020, 1, 0);
    b = mk(enc_r(5'd0, 5'd5, 3'd0, 5'd6), 64'h0, 10'h100, 1, 0);
    offer(a, 1'b1);
    repeat (3) offer(b, 1'b0);
    wb_valid = 1'b1; wb_rd = 5'd5; regs[5] = 64'hDEAD_BEEF_0000_0005;
    offer(b, 1'b0);
    wb_valid = 1'b0;
    offer(b, 1'b1);
    idle(2);
    do_flush();

    // Full queue: third bundle waits; a same-cycle pop does not free the slot.
    exu_ready = 1'b0;
    a = mk(enc_i(12'h001, 5'd20, 3'd0, 5'd11, OP_OPIMM), 64'h1, 10'h080, 1, 0);
    b = mk(enc_i(12'h002, 5'd20, 3'd0, 5'd12, OP_OPIMM), 64'h2, 10'h080, 1, 0);
    c = mk(enc_i(12'h003, 5'd20, 3'd0, 5'd13, OP_OPIMM), 64'h3, 10'h080, 1, 0);
    offer(a, 1'b1);
    chk("full_count1", {62'd0, idu_count}, 64'd1);
    offer(b, 1'b1);
    chk("full_count2", {62'd0, idu_count}, 64'd2);
    offer(c, 1'b0);
    chk("full_hold", {62'd0, idu_count}, 64'd2);
    exu_ready = 1'b1;
    offer(c, 1'b0);
    chk("full_popped", {62'd0, idu_count}, 64'd1);
    exu_ready = 1'b0;
    offer(c, 1'b1);
    chk("full_refill", {62'd0, idu_count}, 64'd2);
    exu_ready = 1'b1;
    idle(3);
    chk("full_drained", {62'd0, idu_count}, 64'd0);

    // Flush with two entries queued and x7 busy.
    exu_ready = 1'b0;
    a = mk(enc_i(12'h000, 5'd20, 3'd2, 5'd7, OP_LOAD), 64'h0, 10'h020, 1, 0);
    b = mk(enc_i(12'h004, 5'd20, 3'd0, 5'd14, OP_OPIMM), 64'h4, 10'h080, 1, 0);
    offer(a, 1'b1);
    offer(b, 1'b1);
    chk("flush_pre_count", {62'd0, idu_count}, 64'd2);
    c = mk(enc_i(12'h005, 5'd20, 3'd0, 5'd15, OP_OPIMM), 64'h5, 10'h080, 1, 0);
    flush = 1'b1;
    sb.delete();
    offer(c, 1'b0);
    flush = 1'b0;
    chk("flush_count", {62'd0, idu_count}, 64'd0);
    chk("flush_valid", {63'd0, idu_valid}, 64'd0);
    a = mk(enc_r(5'd0, 5'd7, 3'd0, 5'd16), 64'h0, 10'h100, 1, 0);
    offer(a, 1'b1);
    chk("flush_after_push", {62'd0, idu_count}, 64'd1);
    exu_ready = 1'b1;
    idle(2);
    do_flush();

    // Same-cycle allocate and retire of x9: set wins, so a reader of x9 stalls.
    exu_ready = 1'b1;
    a = mk(enc_i(12'h009, 5'd20, 3'd0, 5'd9, OP_OPIMM), 64'h9, 10'h080, 1, 0);
    b = mk(enc_r(5'd0, 5'd9, 3'd0, 5'd17), 64'h0, 10'h100, 1, 0);
    wb_valid = 1'b1; wb_rd = 5'd9;
    offer(a, 1'b1);
    wb_valid = 1'b0;
    offer(b, 1'b0);
    wb_valid = 1'b1;
    offer(b, 1'b0);
    wb_valid = 1'b0;
    offer(b, 1'b1);
    idle(2);

    // Asynchronous reset mid-stream with two entries queued.
    exu_ready = 1'b0;
    a = mk(enc_i(12'h011, 5'd20, 3'd0, 5'd18, OP_OPIMM), 64'h11, 10'h080, 1, 0);
    b = mk(enc_i(12'h012, 5'd20, 3'd0, 5'd19, OP_OPIMM), 64'h12, 10'h080, 1, 0);
    offer(a, 1'b1);
    offer(b, 1'b1);
    chk("prerst_count", {62'd0, idu_count}, 64'd2);
    #2;
    rst = 1'b0;
    sb.delete();
    #1;
    chk("arst_valid", {63'd0, idu_valid}, 64'd0);
    chk("arst_count", {62'd0, idu_count}, 64'd0);
    chk("arst_pc", idu_pc, 64'd0);
    chk("arst_inst", {32'd0, idu_inst}, 64'd0);
    chk("arst_imm", idu_imm, 64'd0);
    chk("arst_rs1", idu_rs1_data, 64'd0);
    chk("arst_class", {54'd0, idu_class}, 64'd0);
    chk("arst_wen", {63'd0, idu_rd_wen}, 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    a = mk(enc_r(5'd0, 5'd18, 3'd0, 5'd22), 64'h0, 10'h100, 1, 0);
    offer(a, 1'b1);
    exu_ready = 1'b1;
    idle(2);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/idu_pipe.md
IDU_PIPE -- requirements
Module: idu_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the datapath width for PC, register data and immediate; legal values are 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 2, giving the number of output queue entries; it is a power of two and at least 2.
REQ-003 SHALL have one clock and an asynchronous active-low reset, with ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have the fetch-side ports:
- ifu_valid  in  1  fetch bundle valid.
- ifu_ready  out  1  decode accepts the bundle this cycle.
- ifu_inst  in  32  instruction.
- ifu_pc  in  XLEN  instruction PC.
REQ-005 SHALL have the register-file ports:
- rs1_addr, rs2_addr  out  5  asynchronous read addresses, equal to ifu_inst[19:15] and ifu_inst[24:20].
- rs1_data, rs2_data  in  XLEN  read data.
REQ-006 SHALL have the execute-side ports:
- idu_valid  out  1  queue head valid.
- exu_ready  in  1  downstream pops the head.
- idu_pc  out  XLEN  head field.
- idu_inst  out  32  head field.
- idu_imm  out  XLEN  head field.
- idu_rs1_data, idu_rs2_data  out  XLEN  head fields.
- idu_rd_addr  out  5  head field.
- idu_rd_wen  out  1  head field.
- idu_class  out  10  head field.
- idu_illegal  out  1  head field.
REQ-007 SHALL have the control ports:
- wb_valid  in  1  writeback retires a destination register.
- wb_rd  in  5  register being retired.
- flush  in  1  kill all queued and in-flight work.
- idu_count  out  clog2(DEPTH)+1  queue occupancy.

Function
REQ-008 SHALL decode opcode ifu_inst[6:0] into one-hot idu_class bits 0..9: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OPIMM 0010011, OP 0110011, SYSTEM 1110011.
REQ-009 SHALL treat any other opcode as illegal: idu_class zero, idu_illegal=1, rd_wen=0, no source registers used.
REQ-010 SHALL generate the immediate per RV I/S/B/U/J formats, sign-extended from inst[31] to XLEN; U = {inst[31:12],12'b0} sign-extended; the immediate is zero for OP, SYSTEM and illegal.
REQ-011 SHALL mark source registers as used: rs1 for JALR, BRANCH, LOAD, STORE, OPIMM, OP, and SYSTEM with funct3 in {1,2,3}; rs2 for BRANCH, STORE, OP.
REQ-012 SHALL set rd_wen for LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP, and SYSTEM with funct3!=0, forced to 0 when rd=x0.
REQ-013 SHALL keep a 32-bit busy scoreboard, with bit 0 hardwired to 0.
REQ-014 SHALL assert hazard when a used source register (non-x0) has its busy bit set, using the registered busy value.
REQ-015 SHALL drive ifu_ready = ~full & ~hazard & ~flush, combinationally from the current state and ifu_inst; ifu_ready does not depend on exu_ready, so a full queue blocks push even when the head pops in the same cycle.
REQ-016 SHALL push on ifu_valid & ifu_ready, capturing pc, inst, imm, rs1_data, rs2_data, rd, rd_wen, class and illegal into the tail entry; the data appears at the head no earlier than the next cycle (latency 1).
REQ-017 SHALL set busy[rd] on a push with rd_wen=1.
REQ-018 SHALL clear busy[wb_rd] on wb_valid; when set and clear hit the same register in one cycle, set wins.
REQ-019 SHALL drive idu_valid = (count!=0); the head fields are stable while idu_valid & ~exu_ready.
REQ-020 SHALL pop on idu_valid & exu_ready; when push and pop occur together, count is unchanged.
REQ-021 SHALL wrap read and write pointers modulo DEPTH, with full = (count==DEPTH).
REQ-022 SHALL, on flush, empty the queue (count and pointers to 0) and clear all busy bits at the next edge, and ignore push and wb_valid in that cycle; idu_valid is 0 from the following cycle.
REQ-023 SHALL treat the hazard check on a stalled bundle as re-evaluated every cycle, so that ifu_ready rises in the cycle after the blocking wb_valid.

Reset
REQ-024 SHALL, while rst=0, hold count=0, pointers=0, all busy bits=0, idu_valid=0, and all head output fields=0, asynchronously and regardless of clk.
REQ-025 SHALL discard an in-progress push or pop on reset assertion; after release the first push is accepted when ifu_valid=1, since the queue is empty and there is no hazard.

Verification
REQ-026 SHALL pass: back-to-back independent ADDI x1..x4 with exu_ready=1 -> each pushed on consecutive cycles, each visible one cycle later, count<=1.
REQ-027 SHALL pass: push LW x5, then ADD x6,x5,x0 -> ifu_ready=0 until wb_valid with wb_rd=5, then ifu_ready=1 on the next cycle and the ADD captures the new x5.
REQ-028 SHALL pass: DEPTH=2, exu_ready=0, three valid bundles -> two accepted, count=2, ifu_ready=0; one pop -> third accepted on the following cycle.
REQ-029 SHALL pass: opcode 0000000 -> idu_illegal=1, idu_class=0, idu_rd_wen=0; B-type with imm=-4 at XLEN=64 -> idu_imm=64'hFFFF_FFFF_FFFF_FFFC.
REQ-030 SHALL pass: two entries queued and x7 busy, assert flush -> next cycle count=0, idu_valid=0, an instruction reading x7 accepted immediately.
REQ-031 SHALL pass: reset asserted mid-stream with count=2 -> idu_valid=0 and outputs zero without a clock edge; same-cycle push with rd=9 and wb_rd=9 -> busy[9]=1.
